// File: rtl/osc_freq_monitor.sv
// rtl/osc_freq_monitor.sv - period / loss monitor for a slow asynchronous signal, clocked by the RC oscillator
//
// Purpose:
//   Counts the period of mon_in in clk cycles. It flags measurements outside
//   [MIN_CNT, MAX_CNT] and flags loss when no rising edge arrives for LOSS_CNT
//   cycles. A saturating fault counter accumulates both kinds of event.
//
// Ports:
//   clk           160 MHz oscillator clock (only clock)
//   resetn        asynchronous active-low reset
//   mon_in        asynchronous monitored signal
//   en            monitor enable (synchronous to clk)
//   clr_fault     one-cycle pulse, clears fault_cnt and min/max history
//   period_cnt    last measured period in clk cycles
//   period_valid  one-cycle pulse when period_cnt updates
//   freq_ok       last measurement in window and no loss since
//   loss          no edge seen for LOSS_CNT cycles
//   fault_cnt     saturating count of out-of-window periods plus loss events
//   period_min    smallest period since clear (history build only, else 0)
//   period_max    largest period since clear (history build only, else 0)
//
// Build option:
//   OSC_FREQ_MONITOR_HIST_EN  enables the period_min/period_max history registers.

module osc_freq_monitor #(
  parameter int CNT_W       = 32,
  parameter int MIN_CNT     = 158,
  parameter int MAX_CNT     = 162,
  parameter int LOSS_CNT    = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mon_in,
  input  logic             en,
  input  logic             clr_fault,
  output logic [CNT_W-1:0] period_cnt,
  output logic             period_valid,
  output logic             freq_ok,
  output logic             loss,
  output logic [7:0]       fault_cnt,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max
);

  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_CNT);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] LOSS_V = CNT_W'(LOSS_CNT);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LOST    = 2'd3
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       counter;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   mon_sync;
  logic                   mon_rise;
  logic                   in_win;
  logic                   meas_evt;
  logic                   timeout_evt;
  logic                   fault_evt;

  // Synchronizer chain followed by one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign mon_sync = sync_q[SYNC_STAGES-1];
  assign mon_rise = mon_sync & ~hist_q;
  assign in_win   = (counter >= MIN_V) && (counter <= MAX_V);

  // A measurement is only taken in MEASURE; the first edge in ARM or LOST
  // merely starts the count. Disable overrides everything.
  assign meas_evt    = en && (state == MEASURE) && mon_rise;
  // The edge wins when it coincides with the counter sitting at LOSS_CNT.
  assign timeout_evt = en && ((state == ARM) || (state == MEASURE)) &&
                       !mon_rise && (counter == LOSS_V);
  assign fault_evt   = (meas_evt && !in_win) || timeout_evt;

  // Main FSM with registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      counter      <= '0;
      period_cnt   <= '0;
      period_valid <= 1'b0;
      freq_ok      <= 1'b0;
      loss         <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        counter <= '0;
        freq_ok <= 1'b0;
        loss    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            counter <= '0;
            state   <= ARM;
          end
          ARM: begin
            if (mon_rise) begin
              state   <= MEASURE;
              counter <= ONE_V;
            end else if (counter == LOSS_V) begin
              state   <= LOST;
              loss    <= 1'b1;
              freq_ok <= 1'b0;
            end else begin
              counter <= counter + ONE_V;
            end
          end
          MEASURE: begin
            if (mon_rise) begin
              period_cnt   <= counter;
              period_valid <= 1'b1;
              freq_ok      <= in_win;
              counter      <= ONE_V;
            end else if (counter == LOSS_V) begin
              state   <= LOST;
              loss    <= 1'b1;
              freq_ok <= 1'b0;
            end else begin
              counter <= counter + ONE_V;
            end
          end
          LOST: begin
            if (mon_rise) begin
              state   <= MEASURE;
              counter <= ONE_V;
              loss    <= 1'b0;
            end else begin
              counter <= LOSS_V;
            end
          end
          default: begin
            state   <= IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

  // Saturating fault counter; a fault coinciding with a clear leaves one count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fault_cnt <= 8'd0;
    end else if (clr_fault) begin
      fault_cnt <= {7'd0, fault_evt};
    end else if (fault_evt && (fault_cnt != 8'hFF)) begin
      fault_cnt <= fault_cnt + 8'd1;
    end
  end

`ifdef OSC_FREQ_MONITOR_HIST_EN
  // Extremes of every reported measurement. A measurement coinciding with a
  // clear seeds both registers with the new value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period_min <= '1;
      period_max <= '0;
    end else if (meas_evt) begin
      if (clr_fault) begin
        period_min <= counter;
        period_max <= counter;
      end else begin
        if (counter < period_min) period_min <= counter;
        if (counter > period_max) period_max <= counter;
      end
    end else if (clr_fault) begin
      period_min <= '1;
      period_max <= '0;
    end
  end
`else
  assign period_min = '0;
  assign period_max = '0;
`endif

endmodule
